// File: rtl/cp1506_pkg.sv
// Shared constants for the 1506-bit modular cryptoprocessor: field modulus,
// opcodes, command field layout and the two-share register entry type.
package cp1506_pkg;

  localparam int W    = 1506;
  localparam int NREG = 128;
  localparam int AW   = 7;

  localparam logic [W-1:0] P = 1506'd1658539334852043956605014686969369842243820155059458240864380460354175875596746126442552006529285980003318752448184629099761975446397870870332614114924526019655624366944770281974501212314250998405682106067115619475132937730960746637418716661215852316737808364060021400361715167852784987427099666051667608448888314571788638487985846716927693574019769274326804364407638203115258648742883949562283207610572974523311143132532016594886767069744238342663307263;

  localparam logic [2:0] OP_IDLE = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_COPY = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;

  localparam int INS_HI = 23;
  localparam int INS_LO = 21;
  localparam int RD1_HI = 20;
  localparam int RD1_LO = 14;
  localparam int RD2_HI = 13;
  localparam int RD2_LO = 7;
  localparam int WR_HI  = 6;
  localparam int WR_LO  = 0;

  typedef struct packed {
    logic [W-1:0] s1;
    logic [W-1:0] s2;
  } share_t;

  // Shares are unconstrained W-bit values, so the 1507-bit sum can exceed 2p.
  function automatic logic [W-1:0] share_val(input share_t x);
    return W'(({1'b0, x.s1} + {1'b0, x.s2}) % {1'b0, P});
  endfunction

endpackage

// File: rtl/mod_alu_1506.sv
// Combinational field ALU: collapses both share pairs to values in [0,p)
// and returns the add/sub/mul result as a canonical (r, 0) share pair.
module mod_alu_1506
  import cp1506_pkg::*;
(
  input  share_t     a_i,
  input  share_t     b_i,
  input  logic [2:0] op_i,
  output share_t     res_o
);

  logic [W-1:0] v1, v2, r;
  logic [W:0]   sum;

  assign v1  = share_val(a_i);
  assign v2  = share_val(b_i);
  assign sum = {1'b0, v1} + {1'b0, v2};

  always_comb begin
    r = '0;
    case (op_i)
      OP_ADD:  r = (sum >= {1'b0, P}) ? W'(sum - {1'b0, P}) : sum[W-1:0];
      // Both operands are already reduced, so a single conditional +p fixes a borrow.
      OP_SUB:  r = (v1 >= v2) ? (v1 - v2) : W'({1'b0, v1} + {1'b0, P} - {1'b0, v2});
      OP_MUL:  r = W'(({{W{1'b0}}, v1} * {{W{1'b0}}, v2}) % {{W{1'b0}}, P});
      default: r = '0;
    endcase
    res_o.s1 = r;
    res_o.s2 = '0;
  end

endmodule

// File: rtl/crypto_processor_wrapper_1506.sv
// Register file of 128 share pairs with single-cycle instruction decode;
// operands and the output port read the pre-edge contents combinationally.
module crypto_processor_wrapper_1506
  import cp1506_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         get_output,
  input  logic         data_en,
  input  logic         ins_in,
  input  logic [23:0]  command_in,
  input  logic [W-1:0] din_1,
  input  logic [W-1:0] din_2,
  output logic [W-1:0] dout_1,
  output logic [W-1:0] dout_2
);

  share_t          rf_q [NREG];
  share_t          op1, op2, alu_res, wr_data_d;
  logic            we_d;
  logic [2:0]      ins;
  logic [AW-1:0]   rd1, rd2, wr;

  assign ins = command_in[INS_HI:INS_LO];
  assign rd1 = command_in[RD1_HI:RD1_LO];
  assign rd2 = command_in[RD2_HI:RD2_LO];
  assign wr  = command_in[WR_HI:WR_LO];

  assign op1 = rf_q[rd1];
  assign op2 = rf_q[rd2];

  mod_alu_1506 u_alu (
    .a_i   (op1),
    .b_i   (op2),
    .op_i  (ins),
    .res_o (alu_res)
  );

  always_comb begin
    we_d      = 1'b0;
    wr_data_d = alu_res;
    if (ins_in) begin
      case (ins)
        OP_LOAD: begin
          we_d         = data_en;
          wr_data_d.s1 = din_1;
          wr_data_d.s2 = din_2;
        end
        OP_COPY: begin
          we_d      = 1'b1;
          wr_data_d = op1;
        end
        OP_ADD, OP_SUB, OP_MUL: we_d = 1'b1;
        default: we_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (we_d) begin
      rf_q[wr] <= wr_data_d;
    end
  end

  assign dout_1 = get_output ? op1.s1 : '0;
  assign dout_2 = get_output ? op2.s2 & '0 | op1.s2 : '0;

endmodule

// File: tb/tb_crypto_processor_wrapper_1506.sv
// Directed plus randomized checks of the 1506-bit cryptoprocessor against a
// value-level model (registers held as plain residues mod p).
module tb_crypto_processor_wrapper_1506;
  import cp1506_pkg::*;

  logic         clk, rst, get_output, data_en, ins_in;
  logic [23:0]  command_in;
  logic [W-1:0] din_1, din_2, dout_1, dout_2;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] m [NREG];

  crypto_processor_wrapper_1506 dut (
    .clk        (clk),
    .rst        (rst),
    .get_output (get_output),
    .data_en    (data_en),
    .ins_in     (ins_in),
    .command_in (command_in),
    .din_1      (din_1),
    .din_2      (din_2),
    .dout_1     (dout_1),
    .dout_2     (dout_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] fval(input logic [W-1:0] a, input logic [W-1:0] b);
    return W'(({1'b0, a} + {1'b0, b}) % {1'b0, P});
  endfunction

  function automatic logic [W-1:0] fsub(input logic [W-1:0] a, input logic [W-1:0] b);
    return W'(({1'b0, a} + {1'b0, P} - {1'b0, b}) % {1'b0, P});
  endfunction

  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    return W'(({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, P});
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed ..%h expected ..%h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  // One instruction cycle; the model applies the same instruction to residues.
  task automatic issue(input logic [2:0] op, input int r1, input int r2, input int wd,
                       input logic den, input logic insv,
                       input logic [W-1:0] d1, input logic [W-1:0] d2);
    logic [W-1:0] a, b;
    a = m[r1];
    b = m[r2];
    get_output = 1'b0;
    ins_in     = insv;
    data_en    = den;
    din_1      = d1;
    din_2      = d2;
    command_in = {op, 7'(r1), 7'(r2), 7'(wd)};
    @(posedge clk);
    if (insv && rst === 1'b1) begin
      case (op)
        OP_LOAD: if (den) m[wd] = fval(d1, d2);
        OP_COPY: m[wd] = a;
        OP_ADD:  m[wd] = fval(a, b);
        OP_SUB:  m[wd] = fsub(a, b);
        OP_MUL:  m[wd] = fmul(a, b);
        default: ;
      endcase
    end
    #1;
    ins_in  = 1'b0;
    data_en = 1'b0;
  endtask

  task automatic load(input int wd, input logic [W-1:0] d1, input logic [W-1:0] d2);
    issue(OP_LOAD, 0, 0, wd, 1'b1, 1'b1, d1, d2);
  endtask

  task automatic alu(input logic [2:0] op, input int r1, input int r2, input int wd);
    issue(op, r1, r2, wd, 1'b1, 1'b1, '0, '0);
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [W-1:0] exp);
    ins_in     = 1'b0;
    get_output = 1'b1;
    command_in = {3'd0, 7'(a), 14'd0};
    #1;
    check(tag, fval(dout_1, dout_2), exp);
    get_output = 1'b0;
  endtask

  int iso [14][4] = '{
    '{3, 0, 1, 5}, '{4, 0, 1, 6}, '{5, 5, 3, 7}, '{5, 6, 4, 8},
    '{5, 5, 6, 5}, '{5, 5, 2, 5}, '{3, 7, 8, 6}, '{4, 7, 8, 8},
    '{5, 6, 6, 6}, '{5, 8, 8, 8}, '{3, 5, 6, 7}, '{4, 8, 5, 5},
    '{5, 7, 6, 7}, '{5, 8, 5, 8}
  };

  initial begin
    logic [W-1:0] x1, x2, vx, vz, k1, k2, k3, a, b, c, d, e, f, g;
    logic [2:0]   op;
    int           r1, r2, wd;

    rst = 1'b0; get_output = 1'b0; data_en = 1'b0; ins_in = 1'b0;
    command_in = '0; din_1 = '0; din_2 = '0;
    for (int i = 0; i < NREG; i++) m[i] = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Reset state
    #1;
    check("rst_raw_s1", dout_1, '0);
    check("rst_raw_s2", dout_2, '0);
    rd_chk("rst_r0", 0, '0);
    rd_chk("rst_r127", 127, '0);

    // Load and readback
    load(0, 5, 0);
    rd_chk("load5", 0, 5);
    command_in = {3'd0, 7'd0, 14'd0};
    #1;
    check("gated_out", dout_1 | dout_2, '0);
    load(1, P - 1, 2);
    rd_chk("load_wrap", 1, 1);

    // Arithmetic boundaries
    load(0, P - 1, 0); load(1, 3, 0); alu(OP_ADD, 0, 1, 2);
    rd_chk("add_wrap", 2, 2);
    load(0, 3, 0); load(1, 5, 0); alu(OP_SUB, 0, 1, 2);
    rd_chk("sub_borrow", 2, P - 2);
    alu(OP_SUB, 1, 1, 1);
    rd_chk("sub_self", 1, 0);
    load(0, P - 1, 0); load(1, 0, P - 1); alu(OP_MUL, 0, 1, 2);
    rd_chk("mul_m1", 2, 1);
    load(0, 7, 0); alu(OP_MUL, 0, 0, 0);
    rd_chk("sq_inplace", 0, 49);

    // COPY keeps the share pair verbatim
    x1 = rnd(); x2 = rnd();
    load(10, x1, x2);
    alu(OP_COPY, 10, 0, 11);
    command_in = {3'd0, 7'd11, 14'd0};
    get_output = 1'b1;
    #1;
    check("copy_s1", dout_1, x1);
    check("copy_s2", dout_2, x2);
    get_output = 1'b0;

    // Control gating
    load(20, 9, 0);
    issue(OP_LOAD, 0, 0, 20, 1'b0, 1'b1, rnd(), rnd());
    rd_chk("load_den0", 20, 9);
    issue(OP_ADD, 20, 20, 20, 1'b1, 1'b0, '0, '0);
    rd_chk("ins_off", 20, 9);
    issue(3'd6, 20, 20, 20, 1'b1, 1'b1, rnd(), rnd());
    issue(3'd7, 20, 20, 20, 1'b1, 1'b1, rnd(), rnd());
    rd_chk("op67_noop", 20, 9);

    // 4-isogeny evaluation against a closed-form golden
    for (int i = 0; i < 5; i++) load(i, rnd(), rnd());
    vx = m[0]; vz = m[1]; k1 = m[2]; k2 = m[3]; k3 = m[4];
    for (int i = 0; i < 14; i++) alu(3'(iso[i][0]), iso[i][1], iso[i][2], iso[i][3]);
    a = fval(vx, vz); b = fsub(vx, vz);
    c = fmul(a, k2);  d = fmul(b, k3);
    e = fmul(fmul(a, b), k1);
    f = fmul(fval(c, d), fval(c, d));
    g = fmul(fsub(c, d), fsub(c, d));
    rd_chk("iso_x", 7, fmul(fval(e, f), f));
    rd_chk("iso_z", 8, fmul(g, fsub(g, e)));

    // Randomized instruction stream over 16 registers
    for (int i = 0; i < 16; i++) load(i, rnd(), rnd());
    for (int k = 0; k < 120; k++) begin
      op = 3'($urandom_range(0, 7));
      r1 = $urandom_range(0, 15);
      r2 = $urandom_range(0, 15);
      wd = $urandom_range(0, 15);
      issue(op, r1, r2, wd, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, rnd(), rnd());
      rd_chk("rand_wr", wd, m[wd]);
      rd_chk("rand_rd", r1, m[r1]);
    end

    // Asynchronous reset in the middle of a stream
    alu(OP_MUL, 3, 4, 5);
    #2 rst = 1'b0;
    for (int i = 0; i < NREG; i++) m[i] = '0;
    rd_chk("rst_async", 5, '0);
    issue(OP_LOAD, 0, 0, 6, 1'b1, 1'b1, rnd(), rnd());
    #2 rst = 1'b1;
    for (int i = 0; i < 16; i++) rd_chk("rst_clear", i, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crypto_processor_wrapper_1506.md
# crypto_processor_wrapper_1506

Single-cycle 1506-bit modular-arithmetic cryptoprocessor over the fixed prime p (the isogeny-VDF field modulus), with a 128-entry register file of field elements in two-share redundant form. Host logic loads operands, issues one ADD/SUB/MUL/COPY instruction per clock, and reads results. Sequences such as the 4-isogeny evaluation are driven externally, one instruction per cycle, with no stalls.

## Interface
- Parameters: none. Width W=1506 and modulus P are package constants.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- get_output  in  1  drive register `rd_addr_1` onto the dout shares.
- data_en  in  1  qualifies din for LOAD.
- ins_in  in  1  instruction valid.
- command_in  in  24  {INS[23:21], rd_addr_1[20:14], rd_addr_2[13:7], wr_addr[6:0]}.
- din_1, din_2  in  1506  load shares; loaded value = (din_1 + din_2) mod p.
- dout_1, dout_2  out  1506  read shares; read value = (dout_1 + dout_2) mod p.

## Operation
- Register file: 128 entries. Each entry holds a share pair (s1, s2), each 1506 bits. Its value is v = (s1 + s2) mod p, computed with a 1507-bit sum before reduction.
- INS decode, acting only when ins_in=1:
  - 0 IDLE: no write.
  - 1 LOAD: when data_en=1, R[wr] ← (din_1, din_2) stored verbatim. When data_en=0, no write.
  - 2 COPY: R[wr] ← R[rd1] verbatim.
  - 3 ADD: R[wr] ← ((v1 + v2) mod p, 0).
  - 4 SUB: R[wr] ← ((v1 − v2) mod p, 0). The result is in [0, p), adding p when the difference is negative.
  - 5 MUL: R[wr] ← ((v1 · v2) mod p, 0).
  - 6, 7: no-op.
- v1 = value of R[rd_addr_1]; v2 = value of R[rd_addr_2].
- The same address may appear in any field, e.g. t = t·t, or R8 ← R8 − R5 written to R8.
- ins_in=0: no write, regardless of INS or data_en.
- Output path: dout = R[rd_addr_1] shares when get_output=1, else dout = 0. The output path is independent of ins_in.
- p = 1658539334852043956605014686969369842243820155059458240864380460354175875596746126442552006529285980003318752448184629099761975446397870870332614114924526019655624366944770281974501212314250998405682106067115619475132937730960746637418716661215852316737808364060021400361715167852784987427099666051667608448888314571788638487985846716927693574019769274326804364407638203115258648742883949562283207610572974523311143132532016594886767069744238342663307263. Note p < 2^1506.

## Timing
- Every instruction completes in one cycle. Operands are read combinationally; the result is written at the rising edge at which the instruction is presented.
- An instruction in cycle n+1 sees the result written by cycle n: back-to-back dependent instructions need no bubbles.
- Read-during-write to the same entry in one cycle: operands use the pre-edge contents.
- dout is combinational from the register file and get_output. After the edge that writes R[a], presenting rd_addr_1=a with get_output=1 shows the new value in the same cycle.
- Reset (rst=0), asynchronous: all 128 entries clear to (0, 0) immediately, including during an instruction stream. While rst=0 no writes occur. dout = 0 while get_output=0.

## Structure
- Package `cp1506_pkg`:
  - W=1506 and P.
  - Opcode localparams: IDLE, LOAD, COPY, ADD, SUB, MUL.
  - Command field positions.
- Sub-module `mod_alu_1506`: combinational. Takes two share pairs and an opcode, and returns the reduced result (share reduction, add, sub, mul mod p).
- The wrapper holds the register file, decode and the output mux.

## Test plan
- Load, then read back:
  - LOAD x=5 into R0 (din_2=0); get_output with rd1=0 → dout_1+dout_2 ≡ 5.
  - LOAD (p−1, 2) → read value 1.
- ADD wrap: R0=p−1, R1=3; ADD R2=R0+R1 → R2 = 2.
- SUB borrow: R0=3, R1=5; SUB R2=R0−R1 → R2 = p−2. Also test in-place R1=R1−R1 → 0.
- MUL: R0=p−1, R1=p−1 → 1. Then square in place, R0=R0·R0 with R0=7 → 49.
- 4-isogeny sequence:
  - Load x, z, K1, K2, K3 into R0–R4.
  - Issue 14 back-to-back instructions:
    - R5=R0+R1
    - R6=R0−R1
    - R7=R5·R3
    - R8=R6·R4
    - R5=R5·R6
    - R5=R5·R2
    - R6=R7+R8
    - R8=R7−R8
    - R6²
    - R8²
    - R7=R5+R6
    - R5=R8−R5
    - R7=R7·R6
    - R8=R8·R5
  - R7 and R8 must match a golden model run with the codebase's x/z/K vector.
- Control gating:
  - LOAD with data_en=0 does not write.
  - ins_in=0 with INS=ADD does not write.
  - Asserting rst=0 mid-sequence clears the registers: all subsequent reads return 0.
